// File: rtl/pet_audio_dac.sv
// PET2001 audio output: mixes speaker/cassette/tape bits, slew-limits the level, drops to
// zero after a static idle period, and drives 1-bit DAC pins. PET_AUDIO_DAC_SECOND_ORDER_EN
// selects a second-order modulator in place of the default first-order accumulator.
module pet_audio_dac #(
  parameter int unsigned RAMP_SHIFT = 4,
  parameter int unsigned IDLE_BITS  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_1m,
  input  logic        spk_in,
  input  logic        cass_wr_in,
  input  logic        tape_in,
  input  logic        tape_mon_en,
  input  logic        mute,
  output logic [15:0] level,
  output logic        dac_l,
  output logic        dac_r
);

  logic [1:0] spk_sync, cass_sync, tape_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spk_sync  <= '0;
      cass_sync <= '0;
      tape_sync <= '0;
    end else begin
      spk_sync  <= {spk_sync[0], spk_in};
      cass_sync <= {cass_sync[0], cass_wr_in};
      tape_sync <= {tape_sync[0], tape_in};
    end
  end

  logic [15:0]          spk_term, tape_term, mix, mix_q;
  logic [15:0]          target_d, target_q, level_d, level_q;
  logic [IDLE_BITS-1:0] idle_cnt_d, idle_cnt_q;
  logic                 idle;
  logic signed [16:0]   diff, mag, mag_sh;
  logic signed [15:0]   step;

  always_comb begin
    spk_term  = (spk_sync[1] ^ cass_sync[1]) ? 16'h6000 : 16'h0000;
    tape_term = (tape_sync[1] & tape_mon_en) ? 16'h2000 : 16'h0000;
    mix       = spk_term + tape_term;

    // Idle uses the updated count so the first change after idle un-mutes immediately.
    idle_cnt_d = idle_cnt_q;
    if (mix != mix_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != '1) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    idle     = &idle_cnt_d;
    target_d = (mute || idle) ? 16'h0000 : mix;

    diff    = $signed({1'b0, target_q}) - $signed({1'b0, level_q});
    mag     = diff[16] ? -diff : diff;
    mag_sh  = mag >> RAMP_SHIFT;
    step    = 16'(diff >>> RAMP_SHIFT);
    level_d = level_q;
    if (diff != '0) begin
      if (mag_sh == '0) begin
        level_d = diff[16] ? level_q - 16'd1 : level_q + 16'd1;
      end else begin
        level_d = level_q + step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mix_q      <= '0;
      idle_cnt_q <= '0;
      target_q   <= '0;
      level_q    <= '0;
    end else if (ce_1m) begin
      mix_q      <= mix;
      idle_cnt_q <= idle_cnt_d;
      target_q   <= target_d;
      level_q    <= level_d;
    end
  end

  assign level = level_q;

  logic dac_q;

`ifdef PET_AUDIO_DAC_SECOND_ORDER_EN
  localparam logic signed [21:0] ClampHi = 22'sd262144;
  localparam logic signed [21:0] ClampLo = -22'sd262144;

  function automatic logic signed [19:0] clamp20(input logic signed [21:0] v);
    if (v > ClampHi) begin
      return 20'sd262144;
    end else if (v < ClampLo) begin
      return -20'sd262144;
    end
    return $signed(v[19:0]);
  endfunction

  logic signed [19:0] i1_q, i2_q, i1_d, i2_d;
  logic signed [21:0] fb, i1_sum, i2_sum;

  always_comb begin
    fb     = dac_q ? 22'sd65535 : 22'sd0;
    i1_sum = 22'(i1_q) + $signed({6'b0, level_q}) - fb;
    i1_d   = clamp20(i1_sum);
    i2_sum = 22'(i2_q) + 22'(i1_d) - fb;
    i2_d   = clamp20(i2_sum);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1_q  <= '0;
      i2_q  <= '0;
      dac_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      dac_q <= ~i2_q[19];
    end
  end
`else
  logic [16:0] acc_q;

  // Carry out of the 16-bit phase accumulator is the output bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= {1'b0, acc_q[15:0]} + {1'b0, level_q};
      dac_q <= acc_q[16];
    end
  end
`endif

  assign dac_l = dac_q;
  assign dac_r = dac_q;

endmodule

// File: tb/tb_pet_audio_dac.sv
// Directed bench for pet_audio_dac: expected settle levels are queued as stimulus is applied
// and popped when the DUT level reaches them; a second instance uses a short idle timeout.
module tb_pet_audio_dac;

  logic        clk = 1'b0;
  logic        reset_n, ce_1m;
  logic        spk_in, cass_wr_in, tape_in, tape_mon_en, mute;
  logic [15:0] level, level2;
  logic        dac_l, dac_r, dac_l2, dac_r2;

  int          ce_period = 28;
  int          ce_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];

  pet_audio_dac #(.RAMP_SHIFT(4), .IDLE_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .spk_in(spk_in), .cass_wr_in(cass_wr_in),
    .tape_in(tape_in), .tape_mon_en(tape_mon_en), .mute(mute), .level(level),
    .dac_l(dac_l), .dac_r(dac_r)
  );

  pet_audio_dac #(.RAMP_SHIFT(4), .IDLE_BITS(8)) dut_idle (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .spk_in(spk_in), .cass_wr_in(cass_wr_in),
    .tape_in(tape_in), .tape_mon_en(tape_mon_en), .mute(mute), .level(level2),
    .dac_l(dac_l2), .dac_r(dac_r2)
  );

  always #5 clk = ~clk;

  // One-clk-wide enable every ce_period clocks, changed on the falling edge.
  initial ce_1m = 1'b0;
  always @(negedge clk) begin
    if (ce_cnt >= ce_period - 1) begin
      ce_cnt = 0;
      ce_1m  = 1'b1;
    end else begin
      ce_cnt = ce_cnt + 1;
      ce_1m  = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_ce();
    @(posedge clk iff ce_1m);
    #1;
  endtask

  function automatic logic [15:0] lvl(input bit sel);
    return sel ? level2 : level;
  endfunction

  task automatic wait_level(input string tag, input bit sel, input int budget);
    logic [15:0] expv;
    int n;
    expv = exp_q.pop_front();
    n = 0;
    while (lvl(sel) !== expv && n < budget) begin
      tick_ce();
      n++;
    end
    check(tag, lvl(sel), expv);
  endtask

  task automatic wait_ge(input string tag, input logic [15:0] thresh, input int budget);
    int n;
    n = 0;
    while (level < thresh && n < budget) begin
      tick_ce();
      n++;
    end
    check(tag, level >= thresh, 1);
  endtask

  initial begin
    logic [15:0] prev, maxl, maxstep;
    bit          ok, mono, alt_ok, lr_ok;
    logic        pdac;
    int          n, ones;

    reset_n = 1'b0;
    spk_in = 1'b1; cass_wr_in = 1'b1; tape_in = 1'b1; tape_mon_en = 1'b1; mute = 1'b1;
    repeat (20) tick_clk();
    check("rst_level", level, 16'h0000);
    check("rst_dac_l", dac_l, 1'b0);
    check("rst_dac_r", dac_r, 1'b0);

    spk_in = 1'b0; cass_wr_in = 1'b0; tape_in = 1'b0; tape_mon_en = 1'b0; mute = 1'b0;
    reset_n = 1'b1;
    ok = 1'b1;
    repeat (1000) begin
      tick_clk();
      if (level !== 16'h0000 || dac_l !== 1'b0 || dac_r !== 1'b0) ok = 1'b0;
    end
    check("quiet_after_reset", ok, 1'b1);

    // Speaker step at the nominal 28-clk enable rate.
    spk_in = 1'b1;
    exp_q.push_back(16'h6000);
    prev = level; maxl = level; mono = 1'b1; n = 0;
    while (level !== 16'h6000 && n < 150) begin
      tick_ce();
      if (level < prev) mono = 1'b0;
      if (level > maxl) maxl = level;
      prev = level;
      n++;
    end
    wait_level("spk_settle", 1'b0, 0);
    check("spk_monotonic", mono, 1'b1);
    check("spk_no_overshoot", maxl <= 16'h6000, 1'b1);

    ones = 0;
    repeat (65536) begin
      tick_clk();
      ones += int'(dac_l);
    end
    if (ones >= 24575 && ones <= 24577) ones = 24576;
    check("spk_duty_count", ones, 24576);

    ce_period = 4;
    tape_in = 1'b1; tape_mon_en = 1'b1;
    exp_q.push_back(16'h8000);
    wait_level("tape_mon_on", 1'b0, 200);
    repeat (4) tick_clk();
    pdac = dac_l; alt_ok = 1'b1; lr_ok = 1'b1;
    repeat (16) begin
      tick_clk();
      if (dac_l === pdac) alt_ok = 1'b0;
      if (dac_r !== dac_l) lr_ok = 1'b0;
      pdac = dac_l;
    end
    check("full_scale_alternates", alt_ok, 1'b1);
    check("dac_r_matches_l", lr_ok, 1'b1);

    tape_mon_en = 1'b0;
    exp_q.push_back(16'h6000);
    wait_level("tape_mon_off", 1'b0, 200);

    cass_wr_in = 1'b1;
    exp_q.push_back(16'h0000);
    wait_level("cass_cancels_spk", 1'b0, 200);

    // Mute as level passes 0x2800 so the peak (one more rise) stays below 0x3000.
    cass_wr_in = 1'b0;
    wait_ge("rise_to_2800", 16'h2800, 200);
    mute = 1'b1;
    tick_ce();
    prev = level; mono = 1'b1; maxstep = '0; n = 0;
    while (level !== 16'h0000 && n < 200) begin
      tick_ce();
      if (level > prev) mono = 1'b0;
      else if (prev - level > maxstep) maxstep = prev - level;
      prev = level;
      n++;
    end
    exp_q.push_back(16'h0000);
    wait_level("mute_to_zero", 1'b0, 0);
    check("mute_monotonic", mono, 1'b1);
    check("mute_max_step", maxstep <= 16'h0300, 1'b1);

    mute = 1'b0;
    wait_ge("unmute_rise_5000", 16'h5000, 200);

    // Asynchronous reset between clock edges.
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", level, 16'h0000);
    check("async_rst_dac", {dac_l, dac_r}, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick_clk();
    check("post_rst_level", level, 16'h0000);
    exp_q.push_back(16'h6000);
    wait_level("post_rst_ramp", 1'b0, 200);

    // Short-timeout instance: static speaker goes idle, then wakes on a toggle.
    exp_q.push_back(16'h6000);
    wait_level("idle_inst_up", 1'b1, 200);
    exp_q.push_back(16'h0000);
    wait_level("idle_ramps_down", 1'b1, 400);
    check("long_timeout_not_idle", level, 16'h6000);
    spk_in = 1'b0;
    repeat (4) tick_ce();
    spk_in = 1'b1;
    exp_q.push_back(16'h6000);
    wait_level("idle_wake", 1'b1, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
